// File: rtl/game_timer.sv
// game_timer: prescaled round down-counter with pause, saturating bonus, low-time warning and restart.
module game_timer #(
   parameter int CNT_W         = 8,
   parameter int DEFAULT_LIMIT = 20,
   parameter int PRESCALE      = 50000000,
   parameter int WARN_LEVEL    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic             load_en,
   input  logic [CNT_W-1:0] load_val,
   input  logic             bonus_en,
   input  logic [CNT_W-1:0] bonus_val,
   output logic [CNT_W-1:0] count,
   output logic             running,
   output logic             paused,
   output logic             time_up,
   output logic             time_up_pulse,
   output logic             tick_out,
   output logic             warn
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W:0] MAXC = {1'b0, {CNT_W{1'b1}}};
   localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_LIMIT);
   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
   state_t state, st_n;
   logic [CNT_W-1:0] reload, rl_n, cnt_n, lv, sat;
   logic [PW-1:0] pre, pre_n;
   logic [CNT_W:0] sum;
   logic tick, bon;
   always_comb begin
      lv = load_val != '0 ? load_val : DEF;
      tick = state == RUN && !pause && pre == PW'(PRESCALE - 1);
      bon = bonus_en && !pause && (state == RUN || state == PAUSED);
      // a RUN count is never 0, so subtracting the tick cannot underflow
      sum = {1'b0, count} - (CNT_W+1)'(tick) + (bon ? {1'b0, bonus_val} : '0);
      sat = sum > MAXC ? MAXC[CNT_W-1:0] : sum[CNT_W-1:0];
      st_n = state;
      cnt_n = count;
      rl_n = reload;
      pre_n = pre;
      case (state)
         IDLE:
            if (load_en) begin
               rl_n = lv;
               cnt_n = lv;
            end else if (start) begin
               st_n = RUN;
               pre_n = '0;
            end
         RUN:
            if (pause) st_n = PAUSED;
            else begin
               pre_n = tick ? '0 : pre + PW'(1);
               cnt_n = sat;
               st_n = sat == '0 ? EXPIRED : RUN;
            end
         PAUSED: begin
            st_n = pause ? RUN : PAUSED;
            cnt_n = pause ? count : sat;
         end
         default:
            if (load_en) rl_n = lv;
            else if (start) begin
               st_n = RUN;
               cnt_n = reload;
               pre_n = '0;
            end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= DEF;
         reload <= DEF;
         pre <= '0;
         running <= 1'b0;
         paused <= 1'b0;
         time_up <= 1'b0;
         time_up_pulse <= 1'b0;
         tick_out <= 1'b0;
         warn <= 1'b0;
      end else begin
         state <= st_n;
         count <= cnt_n;
         reload <= rl_n;
         pre <= pre_n;
         running <= st_n == RUN;
         paused <= st_n == PAUSED;
         time_up <= st_n == EXPIRED;
         time_up_pulse <= st_n == EXPIRED && state != EXPIRED;
         tick_out <= tick;
         warn <= (st_n == RUN || st_n == PAUSED) && cnt_n != '0 && int'(cnt_n) <= WARN_LEVEL;
      end
   end
endmodule
